// File: rtl/e203_fpu_dec_issue.sv
// FPU decode-and-issue stage: decodes one-hot FPU info, checks a per-register
// scoreboard and an outstanding-write limit, then stages the op in one register.
module e203_fpu_dec_issue #(
  parameter int INFO_W    = 30,
  parameter int NUM_FREG  = 32,
  parameter int FRIDX_W   = 5,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic [31:0]        i_instr,
  input  logic [INFO_W-1:0]  i_info,
  input  logic [2:0]         i_frm,
  output logic               o_valid,
  input  logic               o_ready,
  output logic [4:0]         o_ftype,
  output logic [2:0]         o_rm,
  output logic               o_illegal,
  output logic               o_frs1en,
  output logic               o_frs2en,
  output logic               o_frs3en,
  output logic               o_frdwen,
  output logic               o_rs1fpu,
  output logic               o_rs2fpu,
  output logic               o_rs3fpu,
  output logic               o_rdfpu,
  output logic [4:0]         o_rs1idx,
  output logic [4:0]         o_rs2idx,
  output logic [4:0]         o_rs3idx,
  output logic [4:0]         o_rdidx,
  input  logic               flush,
  input  logic               wb_valid,
  input  logic [FRIDX_W-1:0] wb_idx,
  output logic [CNT_W-1:0]   outst_cnt
);

  localparam int ONES_W = $clog2(INFO_W + 1);

  // Class masks over the 26 defined ftypes.
  localparam logic [25:0] RS2_OFF = 26'h3C70401;
  localparam logic [25:0] RS3_ON  = 26'h000003C;
  localparam logic [25:0] RD_OFF  = 26'h0000002;
  localparam logic [25:0] RS1_INT = 26'h3800003;
  localparam logic [25:0] RD_INT  = 26'h07F0000;
  localparam logic [25:0] ROUND   = 26'h18307FC;

  logic [NUM_FREG-1:0] pend;
  logic [ONES_W-1:0]   ones;
  logic [4:0]          ftype_d;
  logic [25:0]         dec;
  logic [2:0]          rm_ins, rm_res;
  logic                is_round, illegal;
  logic                rs1en, rs2en, rs3en, rdwen, rs1fpu, rdfpu, fpw;
  logic [4:0]          rs1idx, rs2idx, rs3idx, rdidx;
  logic                staged_fpw, hazard, stall, accept, disp, clr;
  logic [CNT_W:0]      cnt_sum;
  logic                unused_opcode;

  assign unused_opcode = ^i_instr[6:0];

  // NOTE: every variable gets a default before the loop, so this block infers no latch.
  always_comb begin
    ones    = '0;
    ftype_d = 5'd31;
    for (int i = 0; i < INFO_W; i++) begin
      if (i_info[i]) begin
        ones    = ones + ONES_W'(1);
        ftype_d = 5'(i);
      end
    end
    if (ones != ONES_W'(1)) ftype_d = 5'd31;
  end

  assign dec      = i_info[25:0];
  assign rm_ins   = i_instr[14:12];
  assign rm_res   = (rm_ins == 3'b111) ? i_frm : rm_ins;
  assign is_round = |(dec & ROUND);
  assign illegal  = (ones != ONES_W'(1)) | (|i_info[INFO_W-1:26])
                  | (is_round & ((rm_ins == 3'b101) | (rm_ins == 3'b110)))
                  | (is_round & (rm_ins == 3'b111) & (i_frm >= 3'b101));

  assign rs1en  = !illegal;
  assign rs2en  = !illegal & !(|(dec & RS2_OFF));
  assign rs3en  = !illegal & (|(dec & RS3_ON));
  assign rdwen  = !illegal & !(|(dec & RD_OFF));
  assign rs1fpu = !(|(dec & RS1_INT));
  assign rdfpu  = !(|(dec & RD_INT));
  assign fpw    = rdwen & rdfpu;

  assign rs1idx = i_instr[19:15];
  assign rs2idx = i_instr[24:20];
  assign rs3idx = i_instr[31:27];
  assign rdidx  = i_instr[11:7];

  // Illegal ops stage with o_frdwen=0, so they never count as FP writes.
  assign staged_fpw = o_valid & o_frdwen & o_rdfpu;

  function automatic logic hit(input logic [4:0] idx);
    return pend[idx] | (staged_fpw & (o_rdidx == idx));
  endfunction

  always_comb begin
    hazard = (rs1en & rs1fpu & hit(rs1idx)) | (rs2en & hit(rs2idx))
           | (rs3en & hit(rs3idx)) | (fpw & hit(rdidx));
  end

  assign cnt_sum = {1'b0, outst_cnt} + (CNT_W+1)'(staged_fpw);
  assign stall   = hazard | (fpw & (cnt_sum >= (CNT_W+1)'(MAX_OUTST)));
  assign i_ready = !flush & !stall & (!o_valid | o_ready);
  assign accept  = i_valid & i_ready;
  assign disp    = o_valid & o_ready & !flush & staged_fpw;
  assign clr     = wb_valid & pend[wb_idx];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid   <= 1'b0;
      o_ftype   <= '0;
      o_rm      <= '0;
      o_illegal <= 1'b0;
      o_frs1en  <= 1'b0;
      o_frs2en  <= 1'b0;
      o_frs3en  <= 1'b0;
      o_frdwen  <= 1'b0;
      o_rs1fpu  <= 1'b0;
      o_rs2fpu  <= 1'b0;
      o_rs3fpu  <= 1'b0;
      o_rdfpu   <= 1'b0;
      o_rs1idx  <= '0;
      o_rs2idx  <= '0;
      o_rs3idx  <= '0;
      o_rdidx   <= '0;
    end else if (flush) begin
      o_valid <= 1'b0;
    end else if (accept) begin
      o_valid   <= 1'b1;
      o_ftype   <= ftype_d;
      o_rm      <= rm_res;
      o_illegal <= illegal;
      o_frs1en  <= rs1en;
      o_frs2en  <= rs2en;
      o_frs3en  <= rs3en;
      o_frdwen  <= rdwen;
      o_rs1fpu  <= rs1fpu;
      o_rs2fpu  <= rs2en;
      o_rs3fpu  <= rs3en;
      o_rdfpu   <= rdfpu;
      o_rs1idx  <= rs1idx;
      o_rs2idx  <= rs2idx;
      o_rs3idx  <= rs3idx;
      o_rdidx   <= rdidx;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset with the stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend      <= '0;
      outst_cnt <= '0;
    end else begin
      if (clr)  pend[wb_idx]  <= 1'b0;
      if (disp) pend[o_rdidx] <= 1'b1;
      if (disp && !clr)      outst_cnt <= outst_cnt + CNT_W'(1);
      else if (clr && !disp) outst_cnt <= outst_cnt - CNT_W'(1);
    end
  end

  // The WAW stall guarantees a dispatch never targets the register being written back.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(disp && clr && (wb_idx == o_rdidx)))
      else $error("dispatch and writeback hit the same register");
  end

endmodule

// File: tb/tb_e203_fpu_dec_issue.sv
// Directed self-checking bench for e203_fpu_dec_issue: decode, hazards,
// outstanding limit, flush and reset behaviour.
module tb_e203_fpu_dec_issue;

  logic        clk, rst;
  logic        i_valid, i_ready, o_valid, o_ready, o_illegal;
  logic [31:0] i_instr;
  logic [29:0] i_info;
  logic [2:0]  i_frm, o_rm;
  logic [4:0]  o_ftype, o_rs1idx, o_rs2idx, o_rs3idx, o_rdidx, wb_idx;
  logic        o_frs1en, o_frs2en, o_frs3en, o_frdwen;
  logic        o_rs1fpu, o_rs2fpu, o_rs3fpu, o_rdfpu;
  logic        flush, wb_valid;
  logic [3:0]  outst_cnt;

  int checks = 0;
  int errors = 0;
  logic rdy;

  e203_fpu_dec_issue dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .i_instr(i_instr), .i_info(i_info), .i_frm(i_frm),
    .o_valid(o_valid), .o_ready(o_ready), .o_ftype(o_ftype), .o_rm(o_rm),
    .o_illegal(o_illegal), .o_frs1en(o_frs1en), .o_frs2en(o_frs2en),
    .o_frs3en(o_frs3en), .o_frdwen(o_frdwen), .o_rs1fpu(o_rs1fpu),
    .o_rs2fpu(o_rs2fpu), .o_rs3fpu(o_rs3fpu), .o_rdfpu(o_rdfpu),
    .o_rs1idx(o_rs1idx), .o_rs2idx(o_rs2idx), .o_rs3idx(o_rs3idx),
    .o_rdidx(o_rdidx), .flush(flush), .wb_valid(wb_valid), .wb_idx(wb_idx),
    .outst_cnt(outst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [4:0] rs3, input logic [4:0] rs2,
                                     input logic [4:0] rs1, input logic [2:0] rm,
                                     input logic [4:0] rd);
    return {rs3, 2'b00, rs2, rs1, rm, rd, 7'h53};
  endfunction

  function automatic logic [29:0] bit_info(input int b);
    return 30'(1) << b;
  endfunction

  task automatic do_reset();
    i_valid = 0; o_ready = 0; flush = 0; wb_valid = 0; wb_idx = 0;
    i_instr = 0; i_info = 0; i_frm = 0;
    rst = 1;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
  endtask

  // Presents one op for one edge; returns i_ready as seen before that edge.
  task automatic issue(input logic [31:0] ins, input logic [29:0] inf,
                       input logic [2:0] frm, output logic r);
    i_valid = 1; i_instr = ins; i_info = inf; i_frm = frm;
    #1; r = i_ready;
    @(posedge clk); #1;
    i_valid = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid: got %b want 0", o_valid); end
    checks++; if (outst_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", outst_cnt); end
    checks++; if (dut.pend !== 32'h0) begin errors++; $display("FAIL reset_pend: got %h want 0", dut.pend); end
    checks++; if ({o_ftype, o_rm, o_rdidx, o_frs1en, o_rdfpu} !== 15'h0) begin errors++; $display("FAIL reset_outs: got %h want 0", {o_ftype, o_rm, o_rdidx, o_frs1en, o_rdfpu}); end
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL reset_i_ready: got %b want 1", i_ready); end
  endtask

  task automatic test_fadd();
    do_reset();
    issue(mk(0, 2, 1, 3'b000, 3), bit_info(6), 3'b000, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL fadd_accept: got %b want 1", rdy); end
    checks++; if ({o_valid, o_ftype, o_illegal} !== {1'b1, 5'd6, 1'b0}) begin errors++; $display("FAIL fadd_ftype: got %b/%0d/%b want 1/6/0", o_valid, o_ftype, o_illegal); end
    checks++; if ({o_frs1en, o_frs2en, o_frs3en, o_frdwen, o_rdfpu} !== 5'b11011) begin errors++; $display("FAIL fadd_en: got %b want 11011", {o_frs1en, o_frs2en, o_frs3en, o_frdwen, o_rdfpu}); end
    checks++; if ({o_rs1idx, o_rs2idx, o_rdidx} !== {5'd1, 5'd2, 5'd3}) begin errors++; $display("FAIL fadd_idx: got %0d/%0d/%0d want 1/2/3", o_rs1idx, o_rs2idx, o_rdidx); end
    o_ready = 1;
    @(posedge clk); #1;
    o_ready = 0;
    checks++; if ({o_valid, dut.pend[3], outst_cnt} !== {1'b0, 1'b1, 4'd1}) begin errors++; $display("FAIL fadd_dispatch: got v=%b p3=%b cnt=%0d want 0/1/1", o_valid, dut.pend[3], outst_cnt); end
    wb_valid = 1; wb_idx = 3;
    @(posedge clk); #1;
    wb_valid = 0;
    checks++; if ({dut.pend, outst_cnt} !== {32'h0, 4'd0}) begin errors++; $display("FAIL fadd_wb: got pend=%h cnt=%0d want 0/0", dut.pend, outst_cnt); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    o_ready = 1;
    issue(mk(0, 2, 1, 3'b000, 3), bit_info(6), 3'b000, rdy);
    i_valid = 1; i_instr = mk(0, 4, 3, 3'b000, 5); i_info = bit_info(8);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_%0d: got i_ready=%b want 0", c, i_ready); end
      @(posedge clk); #1;
    end
    wb_valid = 1; wb_idx = 3;
    #1;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL b2b_no_bypass: got i_ready=%b want 0", i_ready); end
    @(posedge clk); #1;
    wb_valid = 0;
    checks++; if (i_ready !== 1'b1) begin errors++; $display("FAIL b2b_after_wb: got i_ready=%b want 1", i_ready); end
    @(posedge clk); #1;
    i_valid = 0;
    checks++; if ({o_valid, o_ftype, o_rdidx} !== {1'b1, 5'd8, 5'd5}) begin errors++; $display("FAIL b2b_fmul_staged: got %b/%0d/%0d want 1/8/5", o_valid, o_ftype, o_rdidx); end
  endtask

  task automatic test_rounding();
    do_reset();
    o_ready = 1;
    issue(mk(6, 2, 1, 3'b111, 8), bit_info(2), 3'b010, rdy);
    checks++; if ({o_rm, o_illegal, o_rs3idx} !== {3'b010, 1'b0, 5'd6}) begin errors++; $display("FAIL fmadd_dyn_rm: got rm=%b ill=%b rs3=%0d want 010/0/6", o_rm, o_illegal, o_rs3idx); end
    checks++; if ({o_frs1en, o_frs2en, o_frs3en, o_frdwen, o_rs3fpu} !== 5'b11111) begin errors++; $display("FAIL fmadd_en: got %b want 11111", {o_frs1en, o_frs2en, o_frs3en, o_frdwen, o_rs3fpu}); end
    issue(mk(6, 2, 1, 3'b111, 8), bit_info(2), 3'b101, rdy);
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL illegal_no_stall: got %b want 1", rdy); end
    checks++; if ({o_valid, o_illegal, o_frs1en, o_frs2en, o_frs3en, o_frdwen} !== 6'b110000) begin errors++; $display("FAIL fmadd_bad_frm: got %b want 110000", {o_valid, o_illegal, o_frs1en, o_frs2en, o_frs3en, o_frdwen}); end
    @(posedge clk); #1;
    checks++; if ({dut.pend, outst_cnt} !== {32'h100, 4'd1}) begin errors++; $display("FAIL illegal_no_pend: got pend=%h cnt=%0d want 100/1", dut.pend, outst_cnt); end
  endtask

  task automatic test_illegal();
    do_reset();
    o_ready = 1;
    issue(mk(0, 2, 1, 3'b000, 3), 30'h3, 3'b000, rdy);
    checks++; if ({rdy, o_ftype, o_illegal} !== {1'b1, 5'd31, 1'b1}) begin errors++; $display("FAIL two_hot: got rdy=%b ft=%0d ill=%b want 1/31/1", rdy, o_ftype, o_illegal); end
    issue(mk(0, 2, 1, 3'b000, 3), bit_info(27), 3'b000, rdy);
    checks++; if ({rdy, o_ftype, o_illegal} !== {1'b1, 5'd27, 1'b1}) begin errors++; $display("FAIL reserved_bit: got rdy=%b ft=%0d ill=%b want 1/27/1", rdy, o_ftype, o_illegal); end
    issue(mk(0, 2, 1, 3'b101, 3), bit_info(6), 3'b000, rdy);
    checks++; if ({rdy, o_ftype, o_illegal, o_frdwen} !== {1'b1, 5'd6, 1'b1, 1'b0}) begin errors++; $display("FAIL rm_101: got rdy=%b ft=%0d ill=%b wen=%b want 1/6/1/0", rdy, o_ftype, o_illegal, o_frdwen); end
    issue(mk(0, 0, 1, 3'b001, 9), bit_info(16), 3'b000, rdy);
    checks++; if ({rdy, o_ftype, o_illegal} !== {1'b1, 5'd16, 1'b0}) begin errors++; $display("FAIL fcvt_ws: got rdy=%b ft=%0d ill=%b want 1/16/0", rdy, o_ftype, o_illegal); end
    checks++; if ({o_frs2en, o_frdwen, o_rdfpu, o_rs1fpu, o_rm} !== {4'b0101, 3'b001}) begin errors++; $display("FAIL fcvt_ws_cls: got %b want 0101001", {o_frs2en, o_frdwen, o_rdfpu, o_rs1fpu, o_rm}); end
    @(posedge clk); #1;
    checks++; if ({o_valid, dut.pend, outst_cnt} !== {1'b0, 32'h0, 4'd0}) begin errors++; $display("FAIL fcvt_no_pend: got v=%b pend=%h cnt=%0d want 0/0/0", o_valid, dut.pend, outst_cnt); end
  endtask

  task automatic test_max_outst();
    do_reset();
    o_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      issue(mk(0, 0, 0, 3'b000, 5'(k)), bit_info(6), 3'b000, rdy);
      checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL outst_issue_%0d: got %b want 1", k, rdy); end
    end
    i_valid = 1; i_instr = mk(0, 0, 0, 3'b000, 5); i_info = bit_info(6);
    #1;
    checks++; if ({outst_cnt, i_ready} !== {4'd3, 1'b0}) begin errors++; $display("FAIL outst_limit_staged: got cnt=%0d rdy=%b want 3/0", outst_cnt, i_ready); end
    @(posedge clk); #1;
    checks++; if ({outst_cnt, i_ready} !== {4'd4, 1'b0}) begin errors++; $display("FAIL outst_limit_full: got cnt=%0d rdy=%b want 4/0", outst_cnt, i_ready); end
    wb_valid = 1; wb_idx = 2;
    @(posedge clk); #1;
    wb_valid = 0;
    checks++; if ({outst_cnt, dut.pend, i_ready} !== {4'd3, 32'h1A, 1'b1}) begin errors++; $display("FAIL outst_after_wb: got cnt=%0d pend=%h rdy=%b want 3/1a/1", outst_cnt, dut.pend, i_ready); end
    @(posedge clk); #1;
    i_valid = 0;
    checks++; if ({o_valid, o_rdidx} !== {1'b1, 5'd5}) begin errors++; $display("FAIL outst_fifth: got v=%b rd=%0d want 1/5", o_valid, o_rdidx); end
  endtask

  task automatic test_flush();
    do_reset();
    issue(mk(0, 2, 1, 3'b000, 7), bit_info(7), 3'b000, rdy);
    i_valid = 1; i_instr = mk(0, 2, 1, 3'b000, 9); i_info = bit_info(6);
    #1;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL backpressure: got i_ready=%b want 0", i_ready); end
    @(posedge clk); #1;
    checks++; if ({o_valid, o_ftype, o_rdidx} !== {1'b1, 5'd7, 5'd7}) begin errors++; $display("FAIL hold_stable: got %b/%0d/%0d want 1/7/7", o_valid, o_ftype, o_rdidx); end
    flush = 1; o_ready = 1;
    #1;
    checks++; if (i_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks: got i_ready=%b want 0", i_ready); end
    @(posedge clk); #1;
    flush = 0; i_valid = 0; o_ready = 0;
    checks++; if ({o_valid, dut.pend, outst_cnt} !== {1'b0, 32'h0, 4'd0}) begin errors++; $display("FAIL flush_kill: got v=%b pend=%h cnt=%0d want 0/0/0", o_valid, dut.pend, outst_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    o_ready = 1;
    issue(mk(0, 2, 1, 3'b000, 3), bit_info(6), 3'b000, rdy);
    @(posedge clk); #1;
    o_ready = 0;
    issue(mk(0, 2, 1, 3'b000, 4), bit_info(6), 3'b000, rdy);
    i_valid = 1; i_instr = mk(0, 4, 3, 3'b000, 5); i_info = bit_info(8);
    #1;
    checks++; if ({i_ready, dut.pend[3], o_valid} !== 3'b011) begin errors++; $display("FAIL mid_pre: got rdy=%b p3=%b v=%b want 0/1/1", i_ready, dut.pend[3], o_valid); end
    rst = 1;
    #1;
    checks++; if ({o_valid, dut.pend, outst_cnt, o_rdidx, o_ftype} !== {1'b0, 32'h0, 4'd0, 5'd0, 5'd0}) begin errors++; $display("FAIL mid_reset: got v=%b pend=%h cnt=%0d rd=%0d ft=%0d want all 0", o_valid, dut.pend, outst_cnt, o_rdidx, o_ftype); end
    i_valid = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    test_reset();
    test_fadd();
    test_back_to_back();
    test_rounding();
    test_illegal();
    test_max_outst();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
